// File: rtl/sum_tx_sequencer.sv
// Latches two 4-bit operands from asynchronous save strobes and sends
// "A+B=DD\r\n" as eight bytes through a start/busy UART handshake.
//
// state       | meaning
// S_IDLE      | no report active, waiting for pending
// S_LOAD      | snapshot operands and sum, clear pending, index 0
// S_START     | wait for UART idle, then pulse tx_start
// S_WAIT_ACK  | wait for tx_busy to rise, bounded by ACK_TIMEOUT
// S_WAIT_DONE | wait for tx_busy to fall
// S_NEXT      | finish after byte 7, otherwise advance the index
module sum_tx_sequencer #(
    parameter int ACK_TIMEOUT = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       save_a_n,
    input  logic       save_b_n,
    input  logic [3:0] data_input,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       seq_busy,
    output logic [4:0] sum_out,
    output logic       tx_error
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(ACK_TIMEOUT - 1);
    localparam logic [1:0] FILL_DONE = 2'(SYNC_STAGES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_NEXT
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b;
    logic       r_prev_a, r_prev_b, r_arm_a, r_arm_b;
    logic [1:0] r_fill_cnt;
    logic       w_fill_done, w_lvl_a, w_lvl_b, w_ev_a, w_ev_b;

    logic [3:0] r_reg_a, r_reg_b, r_op_a, r_op_b;
    logic       r_pending;
    logic [4:0] r_sum;
    logic [2:0] r_idx;
    logic [CW-1:0] r_tmo_cnt;
    logic [7:0] r_tx_data;
    logic       r_tx_start, r_tx_error;

    logic       w_load, w_fire, w_timeout, w_advance;
    logic [1:0] w_tens;
    logic [3:0] w_units;
    logic [7:0] w_byte;

    function automatic logic [7:0] f_hex(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    assign w_lvl_a     = r_sync_a[SYNC_STAGES-1];
    assign w_lvl_b     = r_sync_b[SYNC_STAGES-1];
    assign w_fill_done = (r_fill_cnt == FILL_DONE);
    // Arming only once the chain shows a real high keeps a pin held low
    // through reset from looking like a fresh falling edge.
    assign w_ev_a = r_arm_a & r_prev_a & ~w_lvl_a;
    assign w_ev_b = r_arm_b & r_prev_b & ~w_lvl_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_a   <= '1;
            r_sync_b   <= '1;
            r_prev_a   <= 1'b1;
            r_prev_b   <= 1'b1;
            r_arm_a    <= 1'b0;
            r_arm_b    <= 1'b0;
            r_fill_cnt <= 2'd0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], save_a_n};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], save_b_n};
            r_prev_a <= w_lvl_a;
            r_prev_b <= w_lvl_b;
            r_arm_a  <= r_arm_a | (w_fill_done & w_lvl_a);
            r_arm_b  <= r_arm_b | (w_fill_done & w_lvl_b);
            if (!w_fill_done) r_fill_cnt <= r_fill_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fire      = 1'b0;
        w_timeout   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE:      if (r_pending) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (!tx_busy) begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_tmo_cnt == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (r_idx == 3'd7) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tens  = 2'd0;
        w_units = r_sum[3:0];
        if (r_sum >= 5'd30) begin
            w_tens  = 2'd3;
            w_units = 4'(r_sum - 5'd30);
        end else if (r_sum >= 5'd20) begin
            w_tens  = 2'd2;
            w_units = 4'(r_sum - 5'd20);
        end else if (r_sum >= 5'd10) begin
            w_tens  = 2'd1;
            w_units = 4'(r_sum - 5'd10);
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0: w_byte = f_hex(r_op_a);
            3'd1: w_byte = 8'h2B;
            3'd2: w_byte = f_hex(r_op_b);
            3'd3: w_byte = 8'h3D;
            3'd4: w_byte = 8'h30 + {6'd0, w_tens};
            3'd5: w_byte = 8'h30 + {4'd0, w_units};
            3'd6: w_byte = 8'h0D;
            3'd7: w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_a    <= 4'd0;
            r_reg_b    <= 4'd0;
            r_op_a     <= 4'd0;
            r_op_b     <= 4'd0;
            r_pending  <= 1'b0;
            r_sum      <= 5'd0;
            r_idx      <= 3'd0;
            r_tmo_cnt  <= '0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_tx_error <= 1'b0;
        end else begin
            r_tx_start <= w_fire;
            if (w_fire) r_tx_data <= w_byte;
            if (w_ev_a) r_reg_a <= data_input;
            if (w_ev_b) r_reg_b <= data_input;
            // A save_b landing in the LOAD cycle must survive the clear.
            r_pending <= (r_pending & ~w_load) | w_ev_b;
            if (w_load) begin
                r_op_a <= r_reg_a;
                r_op_b <= r_reg_b;
                r_sum  <= {1'b0, r_reg_a} + {1'b0, r_reg_b};
                r_idx  <= 3'd0;
            end else if (w_advance) begin
                r_idx  <= r_idx + 3'd1;
            end
            if (w_fire)
                r_tmo_cnt <= TMO_LOAD;
            else if (r_state == S_WAIT_ACK && r_tmo_cnt != '0)
                r_tmo_cnt <= r_tmo_cnt - 1'b1;
            if (w_timeout) r_tx_error <= 1'b1;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign seq_busy = (r_state != S_IDLE);
    assign sum_out  = r_sum;
    assign tx_error = r_tx_error;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Directed bench for sum_tx_sequencer: UART busy/ack model, byte capture,
// and hand-computed report contents, timeout and reset behaviour.
module tb_sum_tx_sequencer;

    logic       clk;
    logic       reset;
    logic       save_a_n;
    logic       save_b_n;
    logic [3:0] data_input;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       seq_busy;
    logic [4:0] sum_out;
    logic       tx_error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] cap[$];
    int  n_start   = 0;
    int  uart_cnt  = 0;
    bit  uart_en   = 1;
    bit  mon_en    = 0;
    int  idle_cnt  = 0;
    bit  tmo_run   = 0;
    int  tmo_cyc   = 0;

    sum_tx_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .save_a_n   (save_a_n),
        .save_b_n   (save_b_n),
        .data_input (data_input),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .seq_busy   (seq_busy),
        .sum_out    (sum_out),
        .tx_error   (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy rises one cycle after tx_start and stays up 10 cycles.
    always @(negedge clk) begin
        if (mon_en && !seq_busy && !tx_start && cap.size() < 16) idle_cnt++;
        if (tx_start) begin
            cap.push_back(tx_data);
            n_start++;
            tmo_run = 1;
            tmo_cyc = 0;
        end else if (tmo_run) begin
            tmo_cyc++;
            if (tx_error) tmo_run = 0;
        end
        if (tx_start) uart_cnt = 11;
        else if (uart_cnt > 0) uart_cnt--;
        tx_busy = uart_en && (uart_cnt >= 1) && (uart_cnt <= 10);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_save(input logic a, input logic b, input logic [3:0] d);
        data_input = d;
        save_a_n   = !a;
        save_b_n   = !b;
        repeat (6) tick();
        save_a_n = 1'b1;
        save_b_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (cap.size() >= n && !seq_busy) break;
            tick();
        end
        total_cnt++;
        if (i >= budget) $display("FAIL %s wait: got %0d bytes, required %0d", name, cap.size(), n);
        else pass_cnt++;
    endtask

    task automatic check_bytes(input int base, input logic [63:0] exp, input string name);
        logic [7:0] want;
        for (int k = 0; k < 8; k++) begin
            want = exp[63-8*k -: 8];
            total_cnt++;
            if (cap.size() <= base + k) begin
                $display("FAIL %s byte%0d: missing, required %h", name, k, want);
            end else if (cap[base+k] !== want) begin
                $display("FAIL %s byte%0d: got %h required %h", name, k, cap[base+k], want);
            end else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; save_a_n = 1'b1; save_b_n = 1'b1; data_input = 4'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total_cnt++; if (tx_data !== 8'h00) $display("FAIL rst tx_data: got %h required 00", tx_data); else pass_cnt++;
        total_cnt++; if (tx_start !== 1'b0) $display("FAIL rst tx_start: got %b required 0", tx_start); else pass_cnt++;
        total_cnt++; if (seq_busy !== 1'b0) $display("FAIL rst seq_busy: got %b required 0", seq_busy); else pass_cnt++;
        total_cnt++; if (sum_out !== 5'd0) $display("FAIL rst sum_out: got %0d required 0", sum_out); else pass_cnt++;
        total_cnt++; if (tx_error !== 1'b0) $display("FAIL rst tx_error: got %b required 0", tx_error); else pass_cnt++;
        repeat (5) tick();
    endtask

    task automatic test_report(input logic [3:0] a, input logic [3:0] b,
                               input logic [63:0] exp, input logic [4:0] sum, input string name);
        cap.delete();
        do_save(1'b1, 1'b0, a);
        do_save(1'b0, 1'b1, b);
        wait_bytes(8, 400, name);
        total_cnt++; if (cap.size() != 8) $display("FAIL %s count: got %0d required 8", name, cap.size()); else pass_cnt++;
        check_bytes(0, exp, name);
        total_cnt++; if (sum_out !== sum) $display("FAIL %s sum_out: got %0d required %0d", name, sum_out, sum); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        cap.delete();
        do_save(1'b1, 1'b1, 4'h7);
        wait_bytes(8, 400, "simul");
        check_bytes(0, 64'h37_2B_37_3D_31_34_0D_0A, "simul");
        total_cnt++; if (sum_out !== 5'd14) $display("FAIL simul sum_out: got %0d required 14", sum_out); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        cap.delete();
        idle_cnt = 0;
        do_save(1'b1, 1'b0, 4'h5);
        do_save(1'b0, 1'b1, 4'h9);
        mon_en = 1;
        do_save(1'b0, 1'b1, 4'h1);
        wait_bytes(16, 800, "b2b");
        mon_en = 0;
        total_cnt++; if (cap.size() != 16) $display("FAIL b2b count: got %0d required 16", cap.size()); else pass_cnt++;
        check_bytes(0, 64'h35_2B_39_3D_31_34_0D_0A, "b2b_first");
        check_bytes(8, 64'h35_2B_31_3D_30_36_0D_0A, "b2b_second");
        total_cnt++; if (idle_cnt > 2) $display("FAIL b2b idle_gap: got %0d cycles required <=2", idle_cnt); else pass_cnt++;
        total_cnt++; if (sum_out !== 5'd6) $display("FAIL b2b sum_out: got %0d required 6", sum_out); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int i;
        uart_en = 0;
        cap.delete();
        n_start = 0;
        do_save(1'b1, 1'b0, 4'h1);
        do_save(1'b0, 1'b1, 4'h2);
        for (i = 0; i < 1200; i++) begin
            if (tx_error) break;
            tick();
        end
        total_cnt++; if (tx_error !== 1'b1) $display("FAIL tmo tx_error: got %b required 1", tx_error); else pass_cnt++;
        total_cnt++; if (tmo_cyc != 1023) $display("FAIL tmo cycles: got %0d required 1023", tmo_cyc); else pass_cnt++;
        total_cnt++; if (seq_busy !== 1'b0) $display("FAIL tmo seq_busy: got %b required 0", seq_busy); else pass_cnt++;
        repeat (30) tick();
        total_cnt++; if (n_start != 1) $display("FAIL tmo starts: got %0d required 1", n_start); else pass_cnt++;
        total_cnt++; if (cap.size() < 1 || cap[0] !== 8'h31) $display("FAIL tmo byte0: got %h required 31", (cap.size() > 0) ? cap[0] : 8'hxx); else pass_cnt++;
        uart_en = 1;
    endtask

    task automatic test_sticky_error();
        test_report(4'h0, 4'h0, 64'h30_2B_30_3D_30_30_0D_0A, 5'd0, "zero");
        total_cnt++; if (tx_error !== 1'b1) $display("FAIL sticky tx_error: got %b required 1", tx_error); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int i;
        cap.delete();
        do_save(1'b1, 1'b0, 4'h3);
        do_save(1'b0, 1'b1, 4'h4);
        for (i = 0; i < 300; i++) begin
            if (cap.size() >= 3) break;
            tick();
        end
        total_cnt++; if (cap.size() < 3) $display("FAIL mid reached: got %0d bytes required 3", cap.size()); else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++; if (tx_start !== 1'b0) $display("FAIL mid tx_start: got %b required 0", tx_start); else pass_cnt++;
        total_cnt++; if (tx_data !== 8'h00) $display("FAIL mid tx_data: got %h required 00", tx_data); else pass_cnt++;
        total_cnt++; if (seq_busy !== 1'b0) $display("FAIL mid seq_busy: got %b required 0", seq_busy); else pass_cnt++;
        total_cnt++; if (sum_out !== 5'd0) $display("FAIL mid sum_out: got %0d required 0", sum_out); else pass_cnt++;
        total_cnt++; if (tx_error !== 1'b0) $display("FAIL mid tx_error: got %b required 0", tx_error); else pass_cnt++;
        reset = 1'b0;
        repeat (150) tick();
        total_cnt++; if (cap.size() != 3) $display("FAIL mid resume: got %0d bytes required 3", cap.size()); else pass_cnt++;
        total_cnt++; if (seq_busy !== 1'b0) $display("FAIL mid idle: got %b required 0", seq_busy); else pass_cnt++;
    endtask

    task automatic test_held_low();
        int i;
        cap.delete();
        save_b_n = 1'b0;
        data_input = 4'h2;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        total_cnt++; if (seq_busy !== 1'b0 || cap.size() != 0) $display("FAIL held_low: got busy %b bytes %0d required 0 0", seq_busy, cap.size()); else pass_cnt++;
        save_b_n = 1'b1;
        repeat (5) tick();
        save_b_n = 1'b0;
        for (i = 0; i < 20; i++) begin
            if (seq_busy) break;
            tick();
        end
        save_b_n = 1'b1;
        total_cnt++; if (seq_busy !== 1'b1) $display("FAIL held_rearm: got busy %b required 1", seq_busy); else pass_cnt++;
        wait_bytes(8, 400, "rearm");
        check_bytes(0, 64'h30_2B_32_3D_30_32_0D_0A, "rearm");
    endtask

    initial begin
        tx_busy = 1'b0;
        test_reset();
        test_report(4'h5, 4'h9, 64'h35_2B_39_3D_31_34_0D_0A, 5'd14, "a5b9");
        test_report(4'hF, 4'hF, 64'h46_2B_46_3D_33_30_0D_0A, 5'd30, "aFbF");
        test_report(4'hA, 4'h6, 64'h41_2B_36_3D_31_36_0D_0A, 5'd16, "aAb6");
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_sticky_error();
        test_reset_mid();
        test_held_low();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sum_tx_sequencer.md
SUM_TX_SEQUENCER -- requirements
Module: sum_tx_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 1023: max clk cycles to wait for tx_busy to rise after tx_start.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on save_a_n and save_b_n (allowed 2..3).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 save_a_n  input  1  asynchronous active-low request to latch operand A.
REQ-006 save_b_n  input  1  asynchronous active-low request to latch operand B and launch a report.
REQ-007 data_input  input  4  operand value, sampled on a save event.
REQ-008 tx_busy  input  1  UART transmitter busy flag.
REQ-009 tx_data  output  8  byte presented to the UART; valid while tx_start is high.
REQ-010 tx_start  output  1  one-cycle pulse that requests transmission of tx_data.
REQ-011 seq_busy  output  1  high while a report is in progress.
REQ-012 sum_out  output  5  registered A+B from the last launched report.
REQ-013 tx_error  output  1  sticky flag, set on acknowledge timeout.

Function
REQ-014 save_a_n and save_b_n SHALL pass through SYNC_STAGES flops; a save event is one clk cycle at the synchronized 1->0 edge.
REQ-015 A save_a event SHALL load data_input into reg_a the next cycle, in any state.
REQ-016 A save_b event SHALL load data_input into reg_b and set pending; in IDLE it starts a report.
REQ-017 Simultaneous save_a and save_b events SHALL load both registers from the same data_input value, then start the report.
REQ-018 States: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, NEXT.
REQ-019 IDLE -> LOAD when pending=1. LOAD: snapshot reg_a and reg_b, sum_out <= reg_a+reg_b (5-bit, zero-extended), clear pending, byte index=0.
REQ-020 The report SHALL be 8 bytes in order: hex(A), 0x2B '+', hex(B), 0x3D '=', tens digit, units digit, 0x0D, 0x0A.
REQ-021 Hex digits SHALL use 0x30-0x39 for values 0-9 and uppercase 0x41-0x46 for 10-15. Decimal digits SHALL be ASCII, with tens in 0..3.
REQ-022 START: wait until tx_busy=0, then assert tx_start for exactly one cycle with tx_data valid, then go to WAIT_ACK.
REQ-023 WAIT_ACK: go to WAIT_DONE when tx_busy=1. If ACK_TIMEOUT cycles pass with no rise, set tx_error, abandon the report and return to IDLE.
REQ-024 WAIT_DONE: go to NEXT when tx_busy=0.
REQ-025 NEXT: if byte index=7, go to IDLE; otherwise increment the index and go to START.
REQ-026 tx_data SHALL hold its value from the tx_start cycle until the next tx_start.
REQ-027 seq_busy SHALL be 1 in every state except IDLE.
REQ-028 save events during a report SHALL NOT alter the bytes in flight. A save_b during a report leaves pending=1, so IDLE immediately re-enters LOAD. Multiple save_b events during one report SHALL collapse into one pending report.
REQ-029 tx_error SHALL be cleared only by reset.

Reset
REQ-030 On reset: state=IDLE; reg_a, reg_b, sum_out, tx_data=0; tx_start, seq_busy, tx_error, pending=0; synchronizers=1; timeout counter=0.
REQ-031 Reset mid-report SHALL abort the report the next cycle, with no further tx_start, and SHALL drop pending.
REQ-032 After reset deasserts, save pins held low SHALL NOT create a save event until they rise and fall again.

Verification
REQ-033 A=5 then B=9, with a UART model (busy 10 cycles, 1-cycle ack) -> tx_start bytes 35 2B 39 3D 31 34 0D 0A, and sum_out=14.
REQ-034 A=F then B=F -> bytes 46 2B 46 3D 33 30 0D 0A, and sum_out=30. Also A=0,B=0 -> 30 2B 30 3D 30 30 0D 0A.
REQ-035 Second save_b (B=1) during the first report -> first report completes unchanged, then a second report with the new B follows, with no idle gap beyond 2 cycles.
REQ-036 tx_busy tied 0 -> one tx_start, then tx_error=1 after ACK_TIMEOUT cycles, state IDLE, no further tx_start.
REQ-037 Reset asserted after the 3rd byte -> tx_start stays 0, all outputs reach reset values the next cycle, and the old report does not resume.
REQ-038 save_a and save_b in the same cycle with data_input=7 -> bytes 37 2B 37 3D 31 34 0D 0A.
